// File: rtl/path_bist_ctrl.sv
// path_bist_ctrl: launch/capture self-test controller wrapped around the
// `main` path netlist. An LFSR drives the netlist inputs (vec[0]->in1 ..
// vec[3]->in4); after CAPTURE_DELAY settle cycles the netlist output is
// folded into a MISR signature. One run applies N_VECTORS patterns.
// Optional: define PATH_BIST_EXPECT_EN to add a golden-signature compare
// (expected_sig input, registered pass/fail outputs).
module path_bist_ctrl #(
  parameter int                VEC_W         = 4,
  parameter logic [VEC_W-1:0]  SEED          = 4'b1001,
  parameter int                N_VECTORS     = 16,
  parameter int                CAPTURE_DELAY = 1,
  parameter int                SIG_W         = 8,
  parameter logic [SIG_W-1:0]  SIG_POLY      = 8'h1D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [VEC_W-1:0]  vec,
  input  logic              dut_out,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  signature,
  output logic [7:0]        vec_count
`ifdef PATH_BIST_EXPECT_EN
  ,
  input  logic [SIG_W-1:0]  expected_sig,
  output logic              pass,
  output logic              fail
`endif
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LAUNCH  = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  // An all-zero LFSR state would lock up, so a zero seed is forced to 1.
  localparam logic [VEC_W-1:0] SEED_EFF =
    (SEED == '0) ? {{(VEC_W-1){1'b0}}, 1'b1} : SEED;
  localparam logic [3:0] DLY_LAST = (CAPTURE_DELAY > 0) ? 4'(CAPTURE_DELAY - 1) : 4'd0;
  localparam logic [7:0] LAST_IDX = 8'(N_VECTORS - 1);

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [3:0]       r_dly;
  logic [VEC_W-1:0] r_vec;
  logic [SIG_W-1:0] r_sig;
  logic [7:0]       r_cnt;
  logic [SIG_W-1:0] w_sig_nxt;
  logic             w_last_cap;

  // One MISR shift: polynomial feedback from the MSB, new bit into the LSB.
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                 input logic b);
    misr_step = {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? SIG_POLY : '0)
              ^ {{(SIG_W-1){1'b0}}, b};
  endfunction

  // Fibonacci LFSR step, taps x^4+x^3+1 for the default width.
  function automatic logic [VEC_W-1:0] lfsr_step(input logic [VEC_W-1:0] v);
    lfsr_step = {v[VEC_W-2:0], v[VEC_W-1] ^ v[VEC_W-2]};
  endfunction

  assign w_sig_nxt  = misr_step(r_sig, dut_out);
  assign w_last_cap = (r_state == S_CAPTURE) && (r_cnt == LAST_IDX);

  // Next-state decode for the launch/wait/capture sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_nxt = S_LAUNCH;
      S_LAUNCH:  w_state_nxt = (CAPTURE_DELAY > 0) ? S_WAIT : S_CAPTURE;
      S_WAIT:    if (r_dly == DLY_LAST) w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = (r_cnt == LAST_IDX) ? S_DONE : S_LAUNCH;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // State register and settle-delay counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_dly   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_LAUNCH)
        r_dly <= 4'd0;
      else if (r_state == S_WAIT)
        r_dly <= r_dly + 4'd1;
    end
  end

  // Stimulus vector, signature and vector count; all held outside a run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vec <= '0;
      r_sig <= '0;
      r_cnt <= 8'd0;
    end else if ((r_state == S_IDLE) && start) begin
      r_vec <= SEED_EFF;
      r_sig <= '0;
      r_cnt <= 8'd0;
    end else if (r_state == S_CAPTURE) begin
      r_vec <= lfsr_step(r_vec);
      r_sig <= w_sig_nxt;
      r_cnt <= r_cnt + 8'd1;
    end
  end

`ifdef PATH_BIST_EXPECT_EN
  // Golden compare latched on the edge entering DONE, cleared by a new start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass <= 1'b0;
      fail <= 1'b0;
    end else if ((r_state == S_IDLE) && start) begin
      pass <= 1'b0;
      fail <= 1'b0;
    end else if (w_last_cap) begin
      pass <= (w_sig_nxt == expected_sig);
      fail <= (w_sig_nxt != expected_sig);
    end
  end
`endif

  assign vec       = r_vec;
  assign signature = r_sig;
  assign vec_count = r_cnt;
  assign busy      = (r_state == S_LAUNCH) || (r_state == S_WAIT) || (r_state == S_CAPTURE);
  assign done      = (r_state == S_DONE);

endmodule
